// File: rtl/zapper_hit_detect.sv
// ---------------------------------------------------------------------------
// zapper_hit_detect
//
// Light-gun ("zapper") sensor sitting on the composited video bus at the end
// of the draw chain. A trigger latches a WIN x WIN window centred on the aim
// point. The block then waits for the next frame start and counts bright
// pixels inside the window during that frame. When the frame's active area
// ends (first vblnk pixel), it reports hit/miss.
//
// Parameters
//   WIN        window side in pixels (power of two, 2..32)
//   THRESHOLD  minimum R+G+B (4-bit channels) for a bright pixel
//   MIN_COUNT  bright-pixel count at or above which the shot is a hit
//   COUNT_W    width of bright_count (must hold WIN*WIN)
//
// Ports
//   pclk          pixel clock
//   rst_n         asynchronous active-low reset
//   video_bus_in  video bus {hcount, vcount, hsync, vsync, hblnk, vblnk, rgb}
//   trigger       shot request, sampled every cycle
//   aim_x/aim_y   crosshair position, latched when the trigger is accepted
//   busy          high from trigger acceptance until hit_valid
//   hit_valid     one-cycle result strobe
//   hit           result, held until the next hit_valid
//   bright_count  bright pixels counted in the last shot, held
//   video_bus_out (only with ZAPPER_HIT_OVERLAY_EN) bus delayed by one
//                 register stage, window border drawn red while busy
//
// Optional feature macro: ZAPPER_HIT_OVERLAY_EN
// ---------------------------------------------------------------------------

// Video bus layout (video_bus.h field macros)
`ifndef BUS_WIDTH
`define BUS_WIDTH 37
`endif
`ifndef VB_HCOUNT
`define VB_HCOUNT(b) b[37:27]
`endif
`ifndef VB_VCOUNT
`define VB_VCOUNT(b) b[26:16]
`endif
`ifndef VB_HSYNC
`define VB_HSYNC(b) b[15]
`endif
`ifndef VB_VSYNC
`define VB_VSYNC(b) b[14]
`endif
`ifndef VB_HBLNK
`define VB_HBLNK(b) b[13]
`endif
`ifndef VB_VBLNK
`define VB_VBLNK(b) b[12]
`endif
`ifndef VB_RGB
`define VB_RGB(b) b[11:0]
`endif
`ifndef VB_PACK
`define VB_PACK(hc, vc, hs, vs, hb, vb, rgb) {hc, vc, hs, vs, hb, vb, rgb}
`endif

module zapper_hit_detect #(
   parameter int unsigned WIN       = 8,
   parameter int unsigned THRESHOLD = 36,
   parameter int unsigned MIN_COUNT = 4,
   parameter int unsigned COUNT_W   = 11
) (
   input  logic                  pclk,
   input  logic                  rst_n,
   input  logic [`BUS_WIDTH:0]   video_bus_in,
   input  logic                  trigger,
   input  logic [10:0]           aim_x,
   input  logic [10:0]           aim_y,
   output logic                  busy,
   output logic                  hit_valid,
   output logic                  hit,
   output logic [COUNT_W-1:0]    bright_count
`ifdef ZAPPER_HIT_OVERLAY_EN
   ,
   output logic [`BUS_WIDTH:0]   video_bus_out
`endif
);

   localparam logic signed [11:0] HALF    = 12'(WIN / 2);
   localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(WIN * WIN);
   localparam logic [COUNT_W-1:0] MIN_CNT = COUNT_W'(MIN_COUNT);
   localparam logic [5:0]         THR     = 6'(THRESHOLD);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      SCAN,
      REPORT
   } state_t;

   state_t state;

   // Bus fields
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;
   logic        sync_unused;

   assign hcount      = `VB_HCOUNT(video_bus_in);
   assign vcount      = `VB_VCOUNT(video_bus_in);
   assign hblnk       = `VB_HBLNK(video_bus_in);
   assign vblnk       = `VB_VBLNK(video_bus_in);
   assign rgb         = `VB_RGB(video_bus_in);
   assign sync_unused = `VB_HSYNC(video_bus_in) ^ `VB_VSYNC(video_bus_in);

   // Latched window bounds (signed so windows may hang off the top/left)
   logic signed [11:0] x_lo, x_hi, y_lo, y_hi;
   logic [COUNT_W-1:0] count;

   logic signed [11:0] px, py;
   logic [5:0]         rgb_sum;
   logic               in_win;
   logic               bright;
   logic               count_pix;
   logic               frame_start;

   assign px          = $signed({1'b0, hcount});
   assign py          = $signed({1'b0, vcount});
   assign rgb_sum     = {2'b00, rgb[11:8]} + {2'b00, rgb[7:4]} + {2'b00, rgb[3:0]};
   assign bright      = (rgb_sum >= THR);
   assign in_win      = (px >= x_lo) && (px <= x_hi) && (py >= y_lo) && (py <= y_hi);
   assign count_pix   = in_win && !hblnk && !vblnk && bright;
   assign frame_start = (hcount == 11'd0) && (vcount == 11'd0);

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         busy         <= 1'b0;
         hit_valid    <= 1'b0;
         hit          <= 1'b0;
         bright_count <= '0;
         count        <= '0;
         x_lo         <= '0;
         x_hi         <= '0;
         y_lo         <= '0;
         y_hi         <= '0;
      end else begin
         hit_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (trigger) begin
                  x_lo  <= $signed({1'b0, aim_x}) - HALF;
                  x_hi  <= $signed({1'b0, aim_x}) + HALF - 12'sd1;
                  y_lo  <= $signed({1'b0, aim_y}) - HALF;
                  y_hi  <= $signed({1'b0, aim_y}) + HALF - 12'sd1;
                  count <= '0;
                  busy  <= 1'b1;
                  state <= ARM;
               end
            end

            ARM: begin
               // The frame-start pixel is only on the bus during this cycle,
               // so it is counted here rather than one cycle later in SCAN.
               if (frame_start) begin
                  count <= count_pix ? COUNT_W'(1) : '0;
                  state <= SCAN;
               end
            end

            SCAN: begin
               // Result is registered on the first vblnk pixel so that
               // hit_valid appears exactly one cycle after it; the REPORT
               // state is the cycle in which the strobe is visible.
               if (vblnk) begin
                  hit_valid    <= 1'b1;
                  hit          <= (count >= MIN_CNT);
                  bright_count <= count;
                  busy         <= 1'b0;
                  state        <= REPORT;
               end else if (count_pix && (count != MAX_CNT)) begin
                  count <= count + COUNT_W'(1);
               end
            end

            REPORT: begin
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

`ifdef ZAPPER_HIT_OVERLAY_EN
   logic               on_border;
   logic               x_edge, y_edge;
   logic               x_in, y_in;
   logic [`BUS_WIDTH:0] bus_mod;

   assign x_in      = (px >= x_lo) && (px <= x_hi);
   assign y_in      = (py >= y_lo) && (py <= y_hi);
   assign x_edge    = (px == x_lo) || (px == x_hi);
   assign y_edge    = (py == y_lo) || (py == y_hi);
   assign on_border = busy && !hblnk && !vblnk && ((x_edge && y_in) || (y_edge && x_in));

   always_comb begin
      bus_mod = video_bus_in;
      if (on_border) begin
         `VB_RGB(bus_mod) = 12'hF00;
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         video_bus_out <= '0;
      end else begin
         video_bus_out <= bus_mod;
      end
   end
`endif

endmodule
